// File: rtl/e_muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package e_muldiv_pkg;

    // Operation codes carried on i_con_MdOp; codes 6 and 7 are reserved no-ops
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdop_t;

    // Sequencer states: operands latched in IDLE, iterate in RUN, sign fix-up in FIX
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // A zero divisor yields an all-ones quotient built by replicating this bit
    localparam logic DIV0_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/e_muldiv_unit_div_step.sv
// e_div_step: one combinational restoring-division step. Shifts the next
// dividend bit into the partial remainder and subtracts the divisor when it fits.
module e_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; a clear borrow bit means the divisor fits and the quotient bit is 1
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Operands are reduced to magnitudes on entry, processed one bit per cycle,
// and the sign is restored in a final FIX cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN -- when defined, multiplies use a
// single-cycle product and skip RUN; divides stay iterative.
module e_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_con_start,
    input  logic [2:0]       i_con_MdOp,
    input  logic             i_con_flush,
    input  logic [WIDTH-1:0] i_data_A,
    input  logic [WIDTH-1:0] i_data_B,
    output logic [WIDTH-1:0] o_data_Hi,
    output logic [WIDTH-1:0] o_data_Lo,
    output logic             o_con_busy,
    output logic             o_con_done
);

    import e_muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div;
    logic               res_sign;
    logic               rem_sign;
    logic               div_zero;
    logic               done_q;

    logic               op_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Signed ops work on magnitudes; unsigned ops pass operands straight through
    always_comb begin
        op_signed = (i_con_MdOp == MD_MULT) || (i_con_MdOp == MD_DIV);
        mag_a     = (op_signed && i_data_A[WIDTH-1]) ? -i_data_A : i_data_A;
        mag_b     = (op_signed && i_data_B[WIDTH-1]) ? -i_data_B : i_data_B;
    end

    // Shift-add multiply: low half holds the unused multiplier bits, high half the running sum
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    e_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (acc[2*WIDTH-1:WIDTH]),
        .divisor     (opnd),
        .dividend_bit(acc[WIDTH-1]),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    // Restoring divide: remainder in the high half, dividend shifts out as quotient shifts in
    always_comb begin
        div_next = {step_rem, acc[WIDTH-2:0], step_q};
    end

    // Sign restoration and the divide-by-zero result written to HI/LO in FIX
    always_comb begin
        prod_neg = -acc;
        fix_hi   = acc[2*WIDTH-1:WIDTH];
        fix_lo   = acc[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = raw_a;
                fix_lo = {WIDTH{DIV0_QUOTIENT_BIT}};
            end else begin
                if (res_sign) fix_lo = -acc[WIDTH-1:0];
                if (rem_sign) fix_hi = -acc[2*WIDTH-1:WIDTH];
            end
        end else if (res_sign) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    // Sequencer, iteration datapath and HI/LO registers; flush always beats a pending write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div   <= 1'b0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_con_start && !i_con_flush) begin
                        case (i_con_MdOp)
                            MD_MULT, MD_MULTU: begin
                                is_div   <= 1'b0;
                                res_sign <= op_signed & (i_data_A[WIDTH-1] ^ i_data_B[WIDTH-1]);
                                rem_sign <= 1'b0;
                                div_zero <= 1'b0;
                                opnd     <= mag_a;
`ifdef MULDIV_FAST_MUL_EN
                                acc      <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                                state    <= FIX;
`else
                                acc      <= {{WIDTH{1'b0}}, mag_b};
                                cnt      <= CNT_W'(WIDTH - 1);
                                state    <= RUN;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                is_div   <= 1'b1;
                                res_sign <= op_signed & (i_data_A[WIDTH-1] ^ i_data_B[WIDTH-1]);
                                rem_sign <= op_signed & i_data_A[WIDTH-1];
                                div_zero <= (i_data_B == '0);
                                raw_a    <= i_data_A;
                                opnd     <= mag_b;
                                acc      <= {{WIDTH{1'b0}}, mag_a};
                                cnt      <= CNT_W'(WIDTH - 1);
                                state    <= RUN;
                            end
                            MD_MTHI: hi_q <= i_data_A;
                            MD_MTLO: lo_q <= i_data_A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (i_con_flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!i_con_flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_data_Hi  = hi_q;
    assign o_data_Lo  = lo_q;
    assign o_con_busy = (state != IDLE);
    assign o_con_done = done_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit (WIDTH=32). Expected HI/LO come from
// plain 64-bit arithmetic; latency counts the start edge as edge 1.
module tb_e_muldiv_unit;

    localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = WIDTH + 2;
`endif
    localparam int DIV_LAT = WIDTH + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    e_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_con_start(start),
        .i_con_MdOp (op),
        .i_con_flush(flush),
        .i_data_A   (a),
        .i_data_B   (b),
        .o_data_Hi  (hi),
        .o_data_Lo  (lo),
        .o_con_busy (busy),
        .o_con_done (done)
    );

    always #5 clk = ~clk;

    // Reference: {HI,LO} from the architectural definition of each op
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      q;
        longint      r;
        logic [63:0] ux = {32'd0, x};
        logic [63:0] uy = {32'd0, y};
        logic [63:0] res;
        case (o)
            3'd0: res = 64'(sx * sy);
            3'd1: res = ux * uy;
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFFFFFF};
                end else if (o == 3'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'(ux % uy), 32'(ux / uy)};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_done(input int max_edges, input int first, output int edges, output logic busy_at_done);
        bit seen;
        seen = 0;
        edges = first;
        busy_at_done = 1'b1;
        while (!seen && edges < max_edges) begin
            @(posedge clk);
            edges++;
            #1;
            if (done === 1'b1) begin
                seen = 1;
                busy_at_done = busy;
            end
        end
        if (!seen) edges = -1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int edges, output logic busy_after, output logic busy_at_done);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_after = busy;
        wait_done(200, 1, edges, busy_at_done);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks += 4;
        if (hi !== 32'd0)  begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        if (lo !== 32'd0)  begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [2:0]  d_op [5];
        logic [31:0] d_a [5];
        logic [31:0] d_b [5];
        logic [31:0] e_hi [5];
        logic [31:0] e_lo [5];
        int          edges;
        int          lat;
        logic        ba;
        logic        bd;
        d_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2};
        d_a  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        d_b  = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
        e_hi = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd100, 32'h00000000};
        e_lo = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 5; i++) begin
            lat = (d_op[i] < 3'd2) ? MUL_LAT : DIV_LAT;
            run_op(d_op[i], d_a[i], d_b[i], edges, ba, bd);
            checks += 5;
            if (hi !== e_hi[i]) begin errors++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, hi, e_hi[i]); end
            if (lo !== e_lo[i]) begin errors++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, lo, e_lo[i]); end
            if (edges != lat)   begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, edges, lat); end
            if (ba !== 1'b1)    begin errors++; $display("[TB] FAIL directed%0d_busy_after_start: got %b expected 1", i, ba); end
            if (bd !== 1'b0)    begin errors++; $display("[TB] FAIL directed%0d_busy_in_done: got %b expected 0", i, bd); end
            model_hi = e_hi[i];
            model_lo = e_lo[i];
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("[TB] FAIL directed%0d_done_pulse: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_mt();
        op = 3'd4; a = 32'h1234; start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b expected 0", busy); end
        op = 3'd5; a = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks += 4;
        if (hi !== 32'h1234) begin errors++; $display("[TB] FAIL mt_hi: got %h expected 00001234", hi); end
        if (lo !== 32'h5678) begin errors++; $display("[TB] FAIL mt_lo: got %h expected 00005678", lo); end
        if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL mt_busy: got %b expected 0", busy); end
        if (done !== 1'b0)   begin errors++; $display("[TB] FAIL mt_done: got %b expected 0", done); end
        model_hi = 32'h1234;
        model_lo = 32'h5678;
        for (int r = 6; r < 8; r++) begin
            op = 3'(r); a = $urandom; b = $urandom; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            checks += 3;
            if (hi !== model_hi) begin errors++; $display("[TB] FAIL reserved%0d_hi: got %h expected %h", r, hi, model_hi); end
            if (lo !== model_lo) begin errors++; $display("[TB] FAIL reserved%0d_lo: got %h expected %h", r, lo, model_lo); end
            if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL reserved%0d_busy: got %b expected 0", r, busy); end
        end
    endtask

    task automatic test_random(input int n);
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
        int          edges;
        int          lat;
        logic        ba;
        logic        bd;
        for (int i = 0; i < n; i++) begin
            o = 3'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            e = ref_result(o, x, y);
            lat = (o < 3'd2) ? MUL_LAT : DIV_LAT;
            run_op(o, x, y, edges, ba, bd);
            checks += 3;
            if (hi !== e[63:32]) begin errors++; $display("[TB] FAIL random%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, hi, e[63:32]); end
            if (lo !== e[31:0])  begin errors++; $display("[TB] FAIL random%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, lo, e[31:0]); end
            if (edges != lat)    begin errors++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, edges, lat); end
            model_hi = e[63:32];
            model_lo = e[31:0];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
        int          edges;
        logic        ba;
        logic        bd;
        for (int i = 0; i < 3; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            e = ref_result(o, x, y);
            run_op(o, x, y, edges, ba, bd);
            checks += 4;
            if (ba !== 1'b1)     begin errors++; $display("[TB] FAIL b2b%0d_accepted: got busy %b expected 1", i, ba); end
            if (hi !== e[63:32]) begin errors++; $display("[TB] FAIL b2b%0d_hi: got %h expected %h", i, hi, e[63:32]); end
            if (lo !== e[31:0])  begin errors++; $display("[TB] FAIL b2b%0d_lo: got %h expected %h", i, lo, e[31:0]); end
            if (edges != ((o < 3'd2) ? MUL_LAT : DIV_LAT)) begin errors++; $display("[TB] FAIL b2b%0d_latency: got %0d", i, edges); end
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore();
        int   edges;
        logic bd;
        op = 3'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        op = 3'd4; a = 32'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        op = 3'd0; a = 32'd5; b = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, 6, edges, bd);
        checks += 3;
        if (hi !== 32'd6)   begin errors++; $display("[TB] FAIL busy_ignore_hi: got %h expected 00000006", hi); end
        if (lo !== 32'd142) begin errors++; $display("[TB] FAIL busy_ignore_lo: got %h expected 0000008e", lo); end
        if (edges != DIV_LAT) begin errors++; $display("[TB] FAIL busy_ignore_latency: got %0d expected %0d", edges, DIV_LAT); end
        model_hi = 32'd6;
        model_lo = 32'd142;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignore_not_queued: got busy %b expected 0", busy); end
    endtask

    task automatic test_flush(input int flush_edge, input string name);
        int dones;
        op = 3'd2; a = $urandom; b = $urandom | 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (flush_edge - 2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_before: got %b expected 1", name, busy); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_after: got %b expected 0", name, busy); end
        dones = (done === 1'b1) ? 1 : 0;
        repeat (WIDTH + 4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        checks += 3;
        if (dones != 0)      begin errors++; $display("[TB] FAIL %s_no_done: got %0d pulses expected 0", name, dones); end
        if (hi !== model_hi) begin errors++; $display("[TB] FAIL %s_hi: got %h expected %h", name, hi, model_hi); end
        if (lo !== model_lo) begin errors++; $display("[TB] FAIL %s_lo: got %h expected %h", name, lo, model_lo); end
    endtask

    task automatic test_flush_idle();
        int dones;
        op = 3'd5; a = ~model_lo; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (lo !== model_lo) begin errors++; $display("[TB] FAIL flush_idle_mtlo: got %h expected %h", lo, model_lo); end
        op = 3'd3; a = 32'd50; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_divu_busy: got %b expected 0", busy); end
        dones = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        checks += 2;
        if (dones != 0)      begin errors++; $display("[TB] FAIL flush_idle_no_done: got %0d expected 0", dones); end
        if (hi !== model_hi) begin errors++; $display("[TB] FAIL flush_idle_hi: got %h expected %h", hi, model_hi); end
    endtask

    task automatic test_reset_midrun();
        op = 3'd4; a = 32'hA5A5A5A5; start = 1'b1;
        @(posedge clk);
        #1;
        op = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (hi !== 32'd0)  begin errors++; $display("[TB] FAIL midrun_reset_hi: got %h expected 0", hi); end
        if (lo !== 32'd0)  begin errors++; $display("[TB] FAIL midrun_reset_lo: got %h expected 0", lo); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        model_hi = '0;
        model_lo = '0;
        repeat (WIDTH + 4) @(posedge clk);
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_no_resume_busy: got %b expected 0", busy); end
        if (lo !== 32'd0)  begin errors++; $display("[TB] FAIL midrun_no_resume_lo: got %h expected 0", lo); end
    endtask

    initial begin
        $display("[TB] starting e_muldiv_unit bench");
        test_reset();
        test_directed();
        test_mt();
        test_random(30);
        test_back_to_back();
        test_busy_ignore();
        test_flush(10, "flush_run");
        test_flush(WIDTH + 2, "flush_fix");
        test_flush_idle();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
